// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared control-bundle types, bubble constant and encodings
//            for the ctrl_pipe control-path pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  // ALUOp field encodings produced by the ID-stage decoder
  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  // Operand forward-select encodings
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  // Single-bit controls held in ID/EX (Branch is resolved in ID, never stored)
  typedef struct packed {
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
  } ctrl_bundle_t;

  // Subset still live after EX
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  // Subset still live after MEM
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  localparam mem_ctrl_t    MEM_BUBBLE  = '0;
  localparam wb_ctrl_t     WB_BUBBLE   = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use compare; operand forward compare
//                 when CTRL_PIPE_FORWARD_EN is defined.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
`ifdef CTRL_PIPE_FORWARD_EN
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
`endif
  output logic              o_stall
);

  logic w_ex_rd_nz;
  logic w_rs1_hit;
  logic w_rs2_hit;

  always_comb begin
    w_ex_rd_nz = |i_ex_rd;
    w_rs1_hit  = (i_ex_rd == i_id_rs1);
    w_rs2_hit  = (i_ex_rd == i_id_rs2);
    o_stall    = i_ex_mem_read && w_ex_rd_nz && (w_rs1_hit || w_rs2_hit);
  end

`ifdef CTRL_PIPE_FORWARD_EN
  logic w_mem_live;
  logic w_wb_live;

  always_comb begin
    w_mem_live = i_mem_reg_write && (|i_mem_rd);
    w_wb_live  = i_wb_reg_write && (|i_wb_rd);

    // The younger EX/MEM result always wins over MEM/WB
    o_fwd_a = FWD_NONE;
    if (w_mem_live && (i_mem_rd == i_ex_rs1)) begin
      o_fwd_a = FWD_EXMEM;
    end else if (w_wb_live && (i_wb_rd == i_ex_rs1)) begin
      o_fwd_a = FWD_MEMWB;
    end

    o_fwd_b = FWD_NONE;
    if (w_mem_live && (i_mem_rd == i_ex_rs2)) begin
      o_fwd_b = FWD_EXMEM;
    end else if (w_wb_live && (i_wb_rd == i_ex_rs2)) begin
      o_fwd_b = FWD_MEMWB;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// ctrl_pipe : ID/EX, EX/MEM, MEM/WB control-path registers with load-use
//             stall/bubble and branch flush. Optional operand forwarding
//             outputs under macro CTRL_PIPE_FORWARD_EN.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               Branch_i,
  input  logic               MemRead_i,
  input  logic               MemtoReg_i,
  input  logic               MemWrite_i,
  input  logic               ALUSrc_i,
  input  logic               RegWrite_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [REG_AW-1:0]  RS1addr_i,
  input  logic [REG_AW-1:0]  RS2addr_i,
  input  logic [REG_AW-1:0]  RDaddr_i,
  input  logic               Flush_i,
  output logic               Stall_o,
  output logic [ALUOP_W-1:0] EX_ALUOp_o,
  output logic               EX_ALUSrc_o,
  output logic [REG_AW-1:0]  EX_RS1addr_o,
  output logic [REG_AW-1:0]  EX_RS2addr_o,
  output logic               MEM_MemRead_o,
  output logic               MEM_MemWrite_o,
  output logic [REG_AW-1:0]  MEM_RDaddr_o,
  output logic               MEM_RegWrite_o,
  output logic               WB_MemtoReg_o,
  output logic               WB_RegWrite_o,
  output logic [REG_AW-1:0]  WB_RDaddr_o
`ifdef CTRL_PIPE_FORWARD_EN
  ,
  output logic [1:0]         ForwardA_o,
  output logic [1:0]         ForwardB_o
`endif
);

  // ID/EX
  ctrl_bundle_t       r_idex_ctrl;
  logic [ALUOP_W-1:0] r_idex_aluop;
  logic [REG_AW-1:0]  r_idex_rs1;
  logic [REG_AW-1:0]  r_idex_rs2;
  logic [REG_AW-1:0]  r_idex_rd;
  // EX/MEM
  mem_ctrl_t          r_exmem_ctrl;
  logic [REG_AW-1:0]  r_exmem_rd;
  // MEM/WB
  wb_ctrl_t           r_memwb_ctrl;
  logic [REG_AW-1:0]  r_memwb_rd;

  logic               w_stall;
  logic               w_load_bubble;
  logic               w_unused_branch;
  ctrl_bundle_t       w_id_ctrl;

  // Branch is consumed entirely in ID; it only exists here for port parity
  assign w_unused_branch = Branch_i;

  always_comb begin
    w_id_ctrl            = CTRL_BUBBLE;
    w_id_ctrl.mem_read   = MemRead_i;
    w_id_ctrl.mem_to_reg = MemtoReg_i;
    w_id_ctrl.mem_write  = MemWrite_i;
    w_id_ctrl.alu_src    = ALUSrc_i;
    w_id_ctrl.reg_write  = RegWrite_i;
    w_load_bubble        = Flush_i || w_stall;
  end

`ifdef CTRL_PIPE_FORWARD_EN
  hazard_detect #(
    .REG_AW          (REG_AW)
  ) u_hazard_detect (
    .i_ex_mem_read   (r_idex_ctrl.mem_read),
    .i_ex_rd         (r_idex_rd),
    .i_id_rs1        (RS1addr_i),
    .i_id_rs2        (RS2addr_i),
    .i_ex_rs1        (r_idex_rs1),
    .i_ex_rs2        (r_idex_rs2),
    .i_mem_reg_write (r_exmem_ctrl.reg_write),
    .i_mem_rd        (r_exmem_rd),
    .i_wb_reg_write  (r_memwb_ctrl.reg_write),
    .i_wb_rd         (r_memwb_rd),
    .o_fwd_a         (ForwardA_o),
    .o_fwd_b         (ForwardB_o),
    .o_stall         (w_stall)
  );
`else
  hazard_detect #(
    .REG_AW          (REG_AW)
  ) u_hazard_detect (
    .i_ex_mem_read   (r_idex_ctrl.mem_read),
    .i_ex_rd         (r_idex_rd),
    .i_id_rs1        (RS1addr_i),
    .i_id_rs2        (RS2addr_i),
    .o_stall         (w_stall)
  );
`endif

  // Stages always advance; a stall only replaces the ID/EX load with a bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idex_ctrl  <= CTRL_BUBBLE;
      r_idex_aluop <= {ALUOP_W{1'b0}};
      r_idex_rs1   <= {REG_AW{1'b0}};
      r_idex_rs2   <= {REG_AW{1'b0}};
      r_idex_rd    <= {REG_AW{1'b0}};
      r_exmem_ctrl <= MEM_BUBBLE;
      r_exmem_rd   <= {REG_AW{1'b0}};
      r_memwb_ctrl <= WB_BUBBLE;
      r_memwb_rd   <= {REG_AW{1'b0}};
    end else begin
      if (w_load_bubble) begin
        r_idex_ctrl  <= CTRL_BUBBLE;
        r_idex_aluop <= {ALUOP_W{1'b0}};
        r_idex_rs1   <= {REG_AW{1'b0}};
        r_idex_rs2   <= {REG_AW{1'b0}};
        r_idex_rd    <= {REG_AW{1'b0}};
      end else begin
        r_idex_ctrl  <= w_id_ctrl;
        r_idex_aluop <= ALUOp_i;
        r_idex_rs1   <= RS1addr_i;
        r_idex_rs2   <= RS2addr_i;
        r_idex_rd    <= RDaddr_i;
      end

      r_exmem_ctrl.mem_read   <= r_idex_ctrl.mem_read;
      r_exmem_ctrl.mem_write  <= r_idex_ctrl.mem_write;
      r_exmem_ctrl.mem_to_reg <= r_idex_ctrl.mem_to_reg;
      r_exmem_ctrl.reg_write  <= r_idex_ctrl.reg_write;
      r_exmem_rd              <= r_idex_rd;

      r_memwb_ctrl.mem_to_reg <= r_exmem_ctrl.mem_to_reg;
      r_memwb_ctrl.reg_write  <= r_exmem_ctrl.reg_write;
      r_memwb_rd              <= r_exmem_rd;
    end
  end

  always_comb begin
    Stall_o        = w_stall;
    EX_ALUOp_o     = r_idex_aluop;
    EX_ALUSrc_o    = r_idex_ctrl.alu_src;
    EX_RS1addr_o   = r_idex_rs1;
    EX_RS2addr_o   = r_idex_rs2;
    MEM_MemRead_o  = r_exmem_ctrl.mem_read;
    MEM_MemWrite_o = r_exmem_ctrl.mem_write;
    MEM_RDaddr_o   = r_exmem_rd;
    MEM_RegWrite_o = r_exmem_ctrl.reg_write;
    WB_MemtoReg_o  = r_memwb_ctrl.mem_to_reg;
    WB_RegWrite_o  = r_memwb_ctrl.reg_write;
    WB_RDaddr_o    = r_memwb_rd;
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
// tb_ctrl_pipe : directed self-checking bench for ctrl_pipe.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i;
  logic [1:0] ALUOp_i;
  logic [4:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic       Flush_i;
  logic       Stall_o;
  logic [1:0] EX_ALUOp_o;
  logic       EX_ALUSrc_o;
  logic [4:0] EX_RS1addr_o, EX_RS2addr_o;
  logic       MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o;
  logic [4:0] MEM_RDaddr_o;
  logic       WB_MemtoReg_o, WB_RegWrite_o;
  logic [4:0] WB_RDaddr_o;
`ifdef CTRL_PIPE_FORWARD_EN
  logic [1:0] ForwardA_o, ForwardB_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Branch_i       (Branch_i),
    .MemRead_i      (MemRead_i),
    .MemtoReg_i     (MemtoReg_i),
    .MemWrite_i     (MemWrite_i),
    .ALUSrc_i       (ALUSrc_i),
    .RegWrite_i     (RegWrite_i),
    .ALUOp_i        (ALUOp_i),
    .RS1addr_i      (RS1addr_i),
    .RS2addr_i      (RS2addr_i),
    .RDaddr_i       (RDaddr_i),
    .Flush_i        (Flush_i),
    .Stall_o        (Stall_o),
    .EX_ALUOp_o     (EX_ALUOp_o),
    .EX_ALUSrc_o    (EX_ALUSrc_o),
    .EX_RS1addr_o   (EX_RS1addr_o),
    .EX_RS2addr_o   (EX_RS2addr_o),
    .MEM_MemRead_o  (MEM_MemRead_o),
    .MEM_MemWrite_o (MEM_MemWrite_o),
    .MEM_RDaddr_o   (MEM_RDaddr_o),
    .MEM_RegWrite_o (MEM_RegWrite_o),
    .WB_MemtoReg_o  (WB_MemtoReg_o),
    .WB_RegWrite_o  (WB_RegWrite_o),
    .WB_RDaddr_o    (WB_RDaddr_o)
`ifdef CTRL_PIPE_FORWARD_EN
    ,
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o)
`endif
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_set(input logic mr, input logic mtr, input logic mw, input logic as,
                        input logic rw, input logic [1:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    MemRead_i  = mr;  MemtoReg_i = mtr; MemWrite_i = mw;
    ALUSrc_i   = as;  RegWrite_i = rw;  ALUOp_i    = op;
    RS1addr_i  = rs1; RS2addr_i  = rs2; RDaddr_i   = rd;
    #1;
  endtask

  task automatic id_clear;
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic reset_pipe;
    rst_i = 1'b1; Flush_i = 1'b0; Branch_i = 1'b0;
    id_clear();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; Flush_i = 1'b0; Branch_i = 1'b1;
    id_set(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ALUOP_I, 5'd1, 5'd2, 5'd3);
    tick();
    tick();
    n_tests++;
    if ({EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o} !== 13'd0) begin
      n_fail++; $display("FAIL reset_ex: got %h expected 0", {EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o});
    end
    n_tests++;
    if ({MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o} !== 15'd0) begin
      n_fail++; $display("FAIL reset_mem_wb: got %h expected 0",
                         {MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o});
    end
    n_tests++;
    if (Stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", Stall_o);
    end
    rst_i = 1'b0;
    tick();
    n_tests++;
    if ({EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o} !== {2'b11, 1'b1, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL release_ex_load: got %h expected %h",
                         {EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o}, {2'b11, 1'b1, 5'd1, 5'd2});
    end
    tick();
    n_tests++;
    if ({MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o} !== {3'b111, 5'd3}) begin
      n_fail++; $display("FAIL release_mem: got %h expected %h",
                         {MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o}, {3'b111, 5'd3});
    end
    rst_i = 1'b1;
    tick();
    n_tests++;
    if ({MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o, WB_RDaddr_o, EX_ALUOp_o} !== 16'd0) begin
      n_fail++; $display("FAIL midrun_reset: got %h expected 0",
                         {MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o, WB_RDaddr_o, EX_ALUOp_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_pipeline_timing;
    reset_pipe();
    id_set(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd0, 5'd0, 5'd5);
    tick();
    id_clear();
    n_tests++;
    if ({WB_RegWrite_o, MEM_RegWrite_o} !== 2'b00) begin
      n_fail++; $display("FAIL timing_c1: got WB/MEM RegWrite %b expected 00", {WB_RegWrite_o, MEM_RegWrite_o});
    end
    tick();
    n_tests++;
    if ({MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o} !== {1'b1, 5'd5, 1'b0}) begin
      n_fail++; $display("FAIL timing_c2: got %h expected %h", {MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o}, {1'b1, 5'd5, 1'b0});
    end
    tick();
    n_tests++;
    if ({WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o} !== {2'b11, 5'd5}) begin
      n_fail++; $display("FAIL timing_c3: got %h expected %h", {WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o}, {2'b11, 5'd5});
    end
    tick();
    n_tests++;
    if ({WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o} !== 7'd0) begin
      n_fail++; $display("FAIL timing_c4: got %h expected 0", {WB_MemtoReg_o, WB_RegWrite_o, WB_RDaddr_o});
    end
  endtask

  task automatic test_load_use;
    reset_pipe();
    id_set(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LS, 5'd2, 5'd0, 5'd7);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd6, 5'd7, 5'd8);
    n_tests++;
    if (Stall_o !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected 1", Stall_o);
    end
    tick();
    n_tests++;
    if ({Stall_o, EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o} !== 14'd0) begin
      n_fail++; $display("FAIL load_use_bubble: got %h expected 0",
                         {Stall_o, EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o});
    end
    n_tests++;
    if ({MEM_MemRead_o, MEM_RDaddr_o} !== {1'b1, 5'd7}) begin
      n_fail++; $display("FAIL load_use_lw_mem: got %h expected %h", {MEM_MemRead_o, MEM_RDaddr_o}, {1'b1, 5'd7});
    end
    tick();
    n_tests++;
    if ({Stall_o, EX_ALUOp_o, EX_RS1addr_o, EX_RS2addr_o} !== {1'b0, 2'b10, 5'd6, 5'd7}) begin
      n_fail++; $display("FAIL load_use_add_ex: got %h expected %h",
                         {Stall_o, EX_ALUOp_o, EX_RS1addr_o, EX_RS2addr_o}, {1'b0, 2'b10, 5'd6, 5'd7});
    end
    n_tests++;
    if ({MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o} !== 7'd0) begin
      n_fail++; $display("FAIL load_use_bubble_mem: got %h expected 0", {MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o});
    end
  endtask

  task automatic test_x0;
    reset_pipe();
    id_set(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LS, 5'd3, 5'd0, 5'd0);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd0, 5'd0, 5'd4);
    n_tests++;
    if (Stall_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_stall: got %b expected 0", Stall_o);
    end
    tick();
    n_tests++;
    if ({MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o, EX_ALUOp_o} !== {2'b11, 5'd0, 2'b10}) begin
      n_fail++; $display("FAIL x0_regwrite_carried: got %h expected %h",
                         {MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o, EX_ALUOp_o}, {2'b11, 5'd0, 2'b10});
    end
  endtask

  task automatic test_flush;
    reset_pipe();
    Flush_i = 1'b1;
    id_set(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALUOP_I, 5'd1, 5'd2, 5'd9);
    tick();
    Flush_i = 1'b0;
    id_clear();
    n_tests++;
    if ({EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o} !== 13'd0) begin
      n_fail++; $display("FAIL flush_ex: got %h expected 0", {EX_ALUOp_o, EX_ALUSrc_o, EX_RS1addr_o, EX_RS2addr_o});
    end
    tick();
    n_tests++;
    if ({MEM_RegWrite_o, MEM_RDaddr_o} !== 6'd0) begin
      n_fail++; $display("FAIL flush_mem: got %h expected 0", {MEM_RegWrite_o, MEM_RDaddr_o});
    end
    id_set(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALUOP_LS, 5'd1, 5'd0, 5'd4);
    tick();
    Flush_i = 1'b1;
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd4, 5'd0, 5'd10);
    n_tests++;
    if (Stall_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_stall_asserted: got %b expected 1", Stall_o);
    end
    tick();
    Flush_i = 1'b0;
    id_clear();
    n_tests++;
    if ({Stall_o, EX_ALUOp_o, EX_RS1addr_o, MEM_MemRead_o, MEM_RDaddr_o} !== {1'b0, 2'b00, 5'd0, 1'b1, 5'd4}) begin
      n_fail++; $display("FAIL flush_stall_ex: got %h expected %h",
                         {Stall_o, EX_ALUOp_o, EX_RS1addr_o, MEM_MemRead_o, MEM_RDaddr_o}, {1'b0, 2'b00, 5'd0, 1'b1, 5'd4});
    end
    tick();
    n_tests++;
    if ({MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o, WB_RDaddr_o} !== {2'b00, 5'd0, 1'b1, 5'd4}) begin
      n_fail++; $display("FAIL flush_stall_single_bubble: got %h expected %h",
                         {MEM_MemRead_o, MEM_RegWrite_o, MEM_RDaddr_o, WB_RegWrite_o, WB_RDaddr_o}, {2'b00, 5'd0, 1'b1, 5'd4});
    end
  endtask

`ifdef CTRL_PIPE_FORWARD_EN
  task automatic test_forward;
    reset_pipe();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd1, 5'd2, 5'd3);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd1, 5'd2, 5'd3);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_R, 5'd3, 5'd0, 5'd0);
    tick();
    id_clear();
    n_tests++;
    if ({ForwardA_o, ForwardB_o} !== {2'b10, 2'b00}) begin
      n_fail++; $display("FAIL fwd_exmem_priority: got %b expected 1000", {ForwardA_o, ForwardB_o});
    end
    reset_pipe();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R, 5'd1, 5'd2, 5'd3);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_R, 5'd1, 5'd2, 5'd3);
    tick();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_R, 5'd3, 5'd0, 5'd0);
    tick();
    id_clear();
    n_tests++;
    if ({ForwardA_o, ForwardB_o} !== {2'b01, 2'b00}) begin
      n_fail++; $display("FAIL fwd_memwb: got %b expected 0100", {ForwardA_o, ForwardB_o});
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; Flush_i = 1'b0; Branch_i = 1'b0;
    id_clear();
    test_reset();
    test_pipeline_timing();
    test_load_use();
    test_x0();
    test_flush();
`ifdef CTRL_PIPE_FORWARD_EN
    test_forward();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
